// File: rtl/ccff_chain_loader_if.sv
// Byte stream into the CCFF chain loader.
// The producer drives data/valid and the loader answers with ready.
interface ccff_chain_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises a byte stream into a CCFF configuration chain.
// Captures the old chain contents from the tail as readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int DW        = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  ccff_chain_loader_if.slave s_if,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic [DW-1:0]     rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err_abort
);

  localparam int NW = (CHAIN_LEN + DW - 1) / DW;
  localparam int CW = 12;
  localparam int BW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [BW-1:0] sh_n_q, sh_n_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rb_q, rb_d;
  logic [BW-1:0] rb_n_q, rb_n_d;
  logic [DW-1:0] rb_data_q, rb_data_d;
  logic          rb_valid_q, rb_valid_d;
  logic          err_q, err_d;

  logic shift;
  logic last;
  logic accept;
  logic reload;
  logic start_ok;
  logic kill;

  assign shift    = config_enable;
  assign last     = shift && (cnt_q == CW'(CHAIN_LEN - 1));
  assign accept   = s_if.s_ready && s_if.s_valid;
  assign start_ok = (state_q == IDLE) && start && !abort;
  assign kill     = abort && ((state_q != IDLE) || start);

  // Reload in the same cycle the last valid bit leaves, so shifting is gap-free.
  assign reload = (state_q == LOAD) && hold_vld_q &&
                  ((sh_n_q == '0) || (shift && (sh_n_q == BW'(1))));

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = LOAD;
      LOAD: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    s_if.s_ready  = 1'b0;
    unique case (state_q)
      LOAD: begin
        busy          = 1'b1;
        config_enable = (sh_n_q != '0);
        ccff_head     = (sh_n_q != '0) && sh_q[0];
        s_if.s_ready  = !hold_vld_q && (wcnt_q < CW'(NW));
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    sh_n_d     = sh_n_q;
    wcnt_d     = wcnt_q;
    cnt_d      = cnt_q;
    rb_d       = rb_q;
    rb_n_d     = rb_n_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    err_d      = err_q;

    if (shift) begin
      sh_d   = sh_q >> 1;
      sh_n_d = sh_n_q - BW'(1);
      cnt_d  = cnt_q + CW'(1);
      rb_d   = rb_q | (DW'(ccff_tail) << rb_n_q);
      rb_n_d = rb_n_q + BW'(1);
      if ((rb_n_d == BW'(DW)) || last) begin
        rb_data_d  = rb_d;
        rb_valid_d = 1'b1;
        rb_d       = '0;
        rb_n_d     = '0;
      end
    end

    if (reload) begin
      sh_d       = hold_q;
      sh_n_d     = BW'(DW);
      hold_vld_d = 1'b0;
    end

    if (accept) begin
      hold_d     = s_if.s_data;
      hold_vld_d = 1'b1;
      wcnt_d     = wcnt_q + CW'(1);
    end

    // Upper bits of the final word are dropped here.
    if (last) begin
      sh_d   = '0;
      sh_n_d = '0;
    end

    if (start_ok || kill) begin
      hold_vld_d = 1'b0;
      sh_d       = '0;
      sh_n_d     = '0;
      wcnt_d     = '0;
      cnt_d      = '0;
      rb_d       = '0;
      rb_n_d     = '0;
      rb_valid_d = 1'b0;
      err_d      = kill;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      sh_n_q     <= '0;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      rb_q       <= '0;
      rb_n_q     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      sh_n_q     <= sh_n_d;
      wcnt_q     <= wcnt_d;
      cnt_q      <= cnt_d;
      rb_q       <= rb_d;
      rb_n_q     <= rb_n_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      err_q      <= err_d;
    end
  end

  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign err_abort = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Random-stimulus bench for ccff_chain_loader.
// A bit-level chain model feeds ccff_tail and predicts readback.
module tb_ccff_chain_loader;

  localparam int L  = 18;
  localparam int NW = (L + 7) / 8;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b0;
  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic       ccff_tail;
  logic       ccff_head;
  logic       config_enable;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       busy;
  logic       done;
  logic       err_abort;
  logic [L-1:0] chain;

  ccff_chain_loader_if s_if ();

  ccff_chain_loader #(
    .CHAIN_LEN (L),
    .DW        (8)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .s_if          (s_if),
    .ccff_head     (ccff_head),
    .config_enable (config_enable),
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .busy          (busy),
    .done          (done),
    .err_abort     (err_abort)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[L-1];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int sh_n, acc_n, done_n, first_sh, last_sh, done_cyc;
  bit         hq[$];
  logic [7:0] rbq[$];
  int         acq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    sh_n = 0; acc_n = 0; done_n = 0;
    first_sh = -1; last_sh = -1; done_cyc = -1;
    hq.delete(); rbq.delete(); acq.delete();
  endtask

  // Called at a negedge: samples this cycle, then advances one cycle.
  task automatic tick();
    logic ce, hd;
    ce = config_enable;
    hd = ccff_head;
    if (ce) begin
      if (sh_n == 0) first_sh = cyc;
      last_sh = cyc;
      hq.push_back(hd);
      sh_n++;
    end
    if (s_if.s_valid && s_if.s_ready) begin
      acc_n++;
      acq.push_back(cyc);
    end
    if (rb_valid) rbq.push_back(rb_data);
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    @(posedge prog_clk);
    #1;
    if (ce) chain = {chain[L-2:0], hd};
    @(negedge prog_clk);
    cyc++;
  endtask

  task automatic run_load(input int stall_max, input int fixed_stall,
                          input bit mid_start, input bit dir);
    logic [7:0]   w[NW];
    logic [L-1:0] old, expc;
    logic [63:0]  hv, ev;
    logic [7:0]   eb;
    int k, stall, t, st, e, fst, fin, idx;
    for (int i = 0; i < NW; i++) w[i] = 8'($urandom);
    if (dir) begin
      w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h02;
    end
    old = chain;
    clr_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start", 64'(busy), 64'd1);
    chk("err_clear", 64'(err_abort), 64'd0);
    k = 0; stall = 0; t = 0;
    while (done_n == 0 && t < 400) begin
      start = mid_start && (sh_n == 5);
      if (k < NW && stall > 0) begin
        s_if.s_valid = 1'b0;
        stall--;
      end else begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = (k < NW) ? w[k] : 8'($urandom);
      end
      if (s_if.s_valid && s_if.s_ready && k < NW) begin
        k++;
        if (fixed_stall >= 0) stall = (k == 1) ? fixed_stall : 0;
        else stall = $urandom_range(stall_max, 0);
      end
      tick();
      t++;
    end
    start = 1'b0;
    s_if.s_valid = 1'b0;
    chk("done_seen", 64'(done_n), 64'd1);
    hv = '0; ev = '0; expc = '0;
    for (int i = 0; i < hq.size() && i < 64; i++) hv[i] = hq[i];
    for (int i = 0; i < L; i++) begin
      ev[i] = w[i/8][i%8];
      expc[L-1-i] = w[i/8][i%8];
    end
    chk("head_seq", hv, ev);
    chk("shift_cnt", 64'(sh_n), 64'(L));
    chk("words_acc", 64'(acc_n), 64'(NW));
    chk("done_time", 64'(done_cyc), 64'(last_sh + 1));
    chk("chain", 64'(chain), 64'(expc));
    // Word k starts 2 cycles after acceptance, or right after word k-1 ends.
    if (acq.size() >= NW) begin
      e = -100; fst = 0; st = 0;
      for (int i = 0; i < NW; i++) begin
        st = (acq[i] + 2 > e + 1) ? acq[i] + 2 : e + 1;
        if (i == 0) fst = st;
        e = st + 7;
      end
      fin = st + (L - 1 - 8 * (NW - 1));
      chk("first_shift", 64'(first_sh), 64'(fst));
      chk("last_shift", 64'(last_sh), 64'(fin));
    end
    chk("rb_count", 64'(rbq.size()), 64'(NW));
    for (int i = 0; i < rbq.size() && i < NW; i++) begin
      for (int j = 0; j < 8; j++) begin
        idx = 8 * i + j;
        eb[j] = (idx < L) ? old[L-1-idx] : 1'b0;
      end
      chk("rb_word", 64'(rbq[i]), 64'(eb));
    end
    tick();
    chk("idle_after", 64'({busy, done, config_enable}), 64'd0);
  endtask

  task automatic feed_until(input int n);
    int t;
    t = 0;
    while (sh_n < n && t < 200) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'($urandom);
      tick();
      t++;
    end
    s_if.s_valid = 1'b0;
    chk("feed_reach", 64'(sh_n), 64'(n));
  endtask

  initial begin
    int n_rb, acc0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    chain = L'($urandom);
    @(negedge prog_clk);
    repeat (3) tick();
    chk("reset_outs", 64'({s_if.s_ready, ccff_head, config_enable, rb_data,
                           rb_valid, busy, done, err_abort}), 64'd0);
    pReset = 1'b1;
    tick();

    run_load(0, 0, 1'b0, 1'b1);
    chk("gapless", 64'(last_sh - first_sh + 1), 64'(L));
    run_load(0, 5, 1'b0, 1'b0);
    run_load(0, 20, 1'b0, 1'b0);

    clr_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_until(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ce", 64'(config_enable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_err", 64'(err_abort), 64'd1);
    n_rb = rbq.size();
    acc0 = acc_n;
    repeat (20) begin
      s_if.s_valid = 1'b1;
      tick();
    end
    s_if.s_valid = 1'b0;
    chk("abort_no_acc", 64'(acc_n), 64'(acc0));
    chk("abort_no_done", 64'(done_n), 64'd0);
    chk("abort_no_rb", 64'(rbq.size()), 64'(n_rb));
    chk("abort_rb_one", 64'(n_rb), 64'd1);
    chk("abort_err_hold", 64'(err_abort), 64'd1);
    run_load(3, -1, 1'b0, 1'b0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_err", 64'(err_abort), 64'd1);
    tick();
    chk("sa_busy2", 64'(busy), 64'd0);

    clr_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_until(7);
    pReset = 1'b0;
    tick();
    chk("rst_mid_outs", 64'({s_if.s_ready, ccff_head, config_enable, rb_data,
                             rb_valid, busy, done, err_abort}), 64'd0);
    pReset = 1'b1;
    tick();
    chk("rst_no_shift", 64'(config_enable), 64'd0);
    run_load(0, 0, 1'b0, 1'b0);

    run_load(2, -1, 1'b1, 1'b0);
    repeat (4) run_load(4, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameters (name, default, meaning):
- CHAIN_LEN, 18, CCFF bits in the target chain, legal range 1..4095.
- DW, 8, width of the input and readback words, fixed at 8.
REQ-002 Ports (name, direction, width, meaning):
- prog_clk, in, 1, programming clock, the only clock.
- pReset, in, 1, reset.
- start, in, 1, begin one load when IDLE.
- abort, in, 1, terminate the current load.
- s_data, in, 8, bitstream word; bit 0 is shifted first.
- s_valid, in, 1, s_data valid.
- s_ready, out, 1, loader accepts s_data this cycle.
- ccff_head, out, 1, serial data into the chain head.
- config_enable, out, 1, chain advances one bit on a prog_clk edge where this is 1.
- ccff_tail, in, 1, serial data from the chain tail.
- rb_data, out, 8, readback word; bit 0 is the first bit captured.
- rb_valid, out, 1, rb_data valid for exactly one cycle; no backpressure.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse when a load completes.
- err_abort, out, 1, sticky flag set by an abort; cleared by the next accepted start.
REQ-003 One clock; reset is synchronous and active-low.

Function
REQ-004 States: IDLE, LOAD, DONE.
- IDLE -> LOAD on start=1 with abort=0.
- LOAD -> DONE on the edge that completes shift CHAIN_LEN.
- DONE -> IDLE unconditionally after one cycle.
REQ-005 start is ignored outside IDLE.
- If start and abort are both 1 in IDLE, abort wins: state stays IDLE and err_abort is set.
REQ-006 Buffering is two one-word stages, a hold register and a shift register.
- s_ready=1 only in LOAD while the hold register is empty and words accepted < ceil(CHAIN_LEN/8).
REQ-007 The shift register reloads from the hold register in the same cycle its last valid bit shifts out.
- Back-to-back s_valid therefore gives gap-free shifting.
REQ-008 Shift cycle: LOAD with the shift register non-empty.
- In a shift cycle config_enable=1 and ccff_head=current LSB.
- Otherwise config_enable=0 and ccff_head=0.
REQ-009 Exactly CHAIN_LEN shift cycles occur per completed load.
- Upper bits of the final word beyond CHAIN_LEN are discarded and never driven.
REQ-010 A 12-bit shift counter increments once per shift cycle.
- The counter is cleared on entering LOAD.
- The counter never wraps within a load.
REQ-011 Readback:
- In each shift cycle ccff_tail is sampled at that edge into the readback register, filling LSB first.
- After 8 captures, or after the final shift, rb_valid=1 for the next cycle.
- The final readback word has its unfilled upper bits at 0.
REQ-012 done=1 exactly during the DONE cycle.
REQ-013 busy=1 in LOAD and DONE.
REQ-014 abort=1 in LOAD or DONE returns the state to IDLE on the next edge, and on that edge:
- config_enable=0 and s_ready=0 from the next cycle.
- The hold and shift registers are emptied.
- Any partial readback word is discarded; no rb_valid is issued.
- err_abort is set and done is not asserted.
REQ-015 A stall (hold and shift registers both empty in LOAD) holds config_enable=0 indefinitely.
- There is no timeout.

Reset
REQ-016 pReset=0 sampled on a prog_clk edge forces, from the next cycle:
- state=IDLE;
- counters and the readback register cleared;
- hold and shift registers empty;
- s_ready, ccff_head, config_enable, rb_data, rb_valid, busy, done and err_abort all 0.
REQ-017 Reset mid-load takes effect identically, with no further shift cycles.

Verification
REQ-018 With CHAIN_LEN=18, send 0xA5, 0x3C, 0x02 back-to-back after start:
- 18 consecutive config_enable cycles.
- ccff_head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1.
- done one cycle after the last shift; exactly 3 words accepted.
REQ-019 Drive ccff_tail from a reference model holding 18 known bits:
- rb_valid pulses 3 times.
- rb_data equals the old chain contents, LSB first.
- The third word has bits [7:2]=0.
REQ-020 Stall s_valid for 5 cycles after the first word:
- config_enable is low for exactly those stall cycles plus one reload gap if the hold register was empty.
- Total shift cycles are still 18.
REQ-021 Abort after 10 shifts:
- config_enable is 0 the next cycle and busy is 0.
- err_abort=1, no done, and no further s_ready.
- The next start clears err_abort and a fresh load runs 18 shifts.
REQ-022 Assert pReset=0 after 7 shifts: all outputs are 0 the next cycle; a subsequent start loads from bit 0.
REQ-023 Start and abort rules:
- start pulsed during LOAD has no effect on the shift count.
- start and abort together in IDLE leave busy=0 and err_abort=1.
